regfile_write_arbiter: RTL and testbench

- Shares the single write port of the CPU's 20-bit register bank between several requesters, e.g. ALU writeback, load unit, and debug/PC-update.
- Arbitration is round-robin. A lock mode gives a requester back-to-back burst writes.
- Drives one-hot per-register write enables and a shared data word into the bank of 20-bit registers.
- Sits between the execute/writeback stages and the register bank.

---
 rtl/regfile_write_arbiter.sv | 133 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single write port of the register bank, with an
// optional lock mode giving one requester a bounded burst of back-to-back writes.
module regfile_write_arbiter #(
    parameter int NREQ     = 4,
    parameter int NREGS    = 8,
    parameter int AW       = 3,
    parameter int WIDTH    = 20,
    parameter int MAXBURST = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0]               req_lock,
    input  logic [NREQ*AW-1:0]            req_addr,
    input  logic [NREQ*WIDTH-1:0]         req_data,
    output logic [NREQ-1:0]               req_ready,
    output logic [NREGS-1:0]              we,
    output logic [WIDTH-1:0]              wdata,
    output logic [$clog2(NREQ)-1:0]       owner,
    output logic                          locked
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAXBURST + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [CW-1:0]      burst_cnt_q, burst_cnt_d;
    logic [NREGS-1:0]   we_q, we_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;

    logic [NREQ-1:0]    grant;
    logic               found;
    int                 gsel;
    int                 idx;
    logic               fire;
    logic [AW-1:0]      gaddr;

    always_comb begin
        grant = '0;
        found = 1'b0;
        gsel  = 0;
        idx   = 0;
        if (state_q == LOCKED) begin
            gsel = int'(owner_q);
            grant[owner_q] = req_valid[owner_q];
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (int'(rr_ptr_q) + k) % NREQ;
                if (!found && req_valid[idx]) begin
                    found       = 1'b1;
                    grant[idx]  = 1'b1;
                    gsel        = idx;
                end
            end
        end
    end

    assign req_ready = rst ? '0 : grant;
    assign fire      = |req_ready;
    assign gaddr     = req_addr[gsel*AW +: AW];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        we_d        = '0;
        wdata_d     = wdata_q;

        // Out-of-range addresses still complete the handshake but drop the data.
        if (fire && (int'(gaddr) < NREGS)) begin
            we_d[gaddr] = 1'b1;
            wdata_d     = req_data[gsel*WIDTH +: WIDTH];
        end

        case (state_q)
            IDLE: begin
                if (fire) begin
                    rr_ptr_d = PW'((gsel + 1) % NREQ);
                    if (req_lock[gsel] && (MAXBURST > 1)) begin
                        state_d     = LOCKED;
                        owner_d     = PW'(gsel);
                        burst_cnt_d = CW'(1);
                    end
                end
            end
            LOCKED: begin
                // burst_cnt counts grants already made; release on the MAXBURST-th.
                if (fire && req_lock[owner_q] && (burst_cnt_q < CW'(MAXBURST - 1))) begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                end else begin
                    state_d     = IDLE;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            we_q        <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
        end
    end

    assign we     = we_q;
    assign wdata  = wdata_q;
    assign owner  = owner_q;
    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: vector table for arbitration and
// lock sequences, plus hand-written out-of-range, mid-burst reset and MAXBURST=1 cases.
module tb_regfile_write_arbiter;

    localparam int NREQ  = 4;
    localparam int NREGS = 6;
    localparam int AW    = 3;
    localparam int WIDTH = 20;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req_valid, req_lock;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready, req_ready1;
    logic [NREGS-1:0]      we, we1;
    logic [WIDTH-1:0]      wdata, wdata1;
    logic [1:0]            owner, owner1;
    logic                  locked, locked1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.NREQ(NREQ), .NREGS(NREGS), .AW(AW), .WIDTH(WIDTH), .MAXBURST(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
        .we(we), .wdata(wdata), .owner(owner), .locked(locked)
    );

    regfile_write_arbiter #(.NREQ(NREQ), .NREGS(NREGS), .AW(AW), .WIDTH(WIDTH), .MAXBURST(1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_lock(req_lock),
        .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready1),
        .we(we1), .wdata(wdata1), .owner(owner1), .locked(locked1)
    );

    typedef struct {
        logic             rst;
        logic [3:0]       valid;
        logic [3:0]       lock;
        logic [3:0]       ready;
        logic [NREGS-1:0] we;
        logic [19:0]      wdata;
        logic             locked;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_defaults();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]       = AW'(i);
            req_data[i*WIDTH +: WIDTH] = WIDTH'(32'h10000 + i);
        end
    endtask

    // Drive one cycle: inputs shortly after a rising edge, ready checked mid-cycle,
    // registered outputs checked just after the next rising edge.
    task automatic run_cycle(input string name, input logic r, input logic [3:0] v, input logic [3:0] l,
                             input logic [3:0] exp_ready, input logic [NREGS-1:0] exp_we,
                             input logic [19:0] exp_wdata, input logic exp_locked);
        rst = r; req_valid = v; req_lock = l;
        #2;
        chk({name, ".ready"}, 32'(req_ready), 32'(exp_ready));
        @(posedge clk); #1;
        chk({name, ".we"}, 32'(we), 32'(exp_we));
        chk({name, ".wdata"}, 32'(wdata), 32'(exp_wdata));
        chk({name, ".locked"}, 32'(locked), 32'(exp_locked));
    endtask

    initial begin
        // reset with all valid high
        vecs[0]  = '{1'b1, 4'hF, 4'h0, 4'h0, 6'h00, 20'h00000, 1'b0};
        vecs[1]  = '{1'b1, 4'hF, 4'h0, 4'h0, 6'h00, 20'h00000, 1'b0};
        // round robin
        vecs[2]  = '{1'b0, 4'hF, 4'h0, 4'h1, 6'h01, 20'h10000, 1'b0};
        vecs[3]  = '{1'b0, 4'hF, 4'h0, 4'h2, 6'h02, 20'h10001, 1'b0};
        vecs[4]  = '{1'b0, 4'hF, 4'h0, 4'h4, 6'h04, 20'h10002, 1'b0};
        vecs[5]  = '{1'b0, 4'hF, 4'h0, 4'h8, 6'h08, 20'h10003, 1'b0};
        vecs[6]  = '{1'b0, 4'hF, 4'h0, 4'h1, 6'h01, 20'h10000, 1'b0};
        vecs[7]  = '{1'b0, 4'hF, 4'h0, 4'h2, 6'h02, 20'h10001, 1'b0};
        vecs[8]  = '{1'b0, 4'hF, 4'h0, 4'h4, 6'h04, 20'h10002, 1'b0};
        vecs[9]  = '{1'b0, 4'hF, 4'h0, 4'h8, 6'h08, 20'h10003, 1'b0};
        // move rr_ptr to 2
        vecs[10] = '{1'b0, 4'h3, 4'h0, 4'h1, 6'h01, 20'h10000, 1'b0};
        vecs[11] = '{1'b0, 4'h2, 4'h0, 4'h2, 6'h02, 20'h10001, 1'b0};
        // requester 2 locks: four grants, then requester 3
        vecs[12] = '{1'b0, 4'hF, 4'h4, 4'h4, 6'h04, 20'h10002, 1'b1};
        vecs[13] = '{1'b0, 4'hF, 4'hD, 4'h4, 6'h04, 20'h10002, 1'b1};
        vecs[14] = '{1'b0, 4'hF, 4'h4, 4'h4, 6'h04, 20'h10002, 1'b1};
        vecs[15] = '{1'b0, 4'hF, 4'h4, 4'h4, 6'h04, 20'h10002, 1'b0};
        vecs[16] = '{1'b0, 4'hF, 4'h4, 4'h8, 6'h08, 20'h10003, 1'b0};
        // requester 1 locks then abandons
        vecs[17] = '{1'b0, 4'h2, 4'h2, 4'h2, 6'h02, 20'h10001, 1'b1};
        vecs[18] = '{1'b0, 4'hD, 4'h2, 4'h0, 6'h00, 20'h10001, 1'b0};
        vecs[19] = '{1'b0, 4'hF, 4'h0, 4'h4, 6'h04, 20'h10002, 1'b0};
        vecs[20] = '{1'b0, 4'h0, 4'h0, 4'h0, 6'h00, 20'h10002, 1'b0};

        rst = 1'b1; req_valid = '0; req_lock = '0;
        set_defaults();
        @(posedge clk); #1;

        for (int i = 0; i < 21; i++) begin
            run_cycle($sformatf("vec%0d", i), vecs[i].rst, vecs[i].valid, vecs[i].lock,
                      vecs[i].ready, vecs[i].we, vecs[i].wdata, vecs[i].locked);
        end

        // out-of-range address, rr_ptr currently 3
        req_addr[0 +: AW]    = 3'd7;
        req_data[0 +: WIDTH] = 20'hABCDE;
        run_cycle("oor", 1'b0, 4'h1, 4'h0, 4'h1, 6'h00, 20'h10002, 1'b0);
        set_defaults();
        run_cycle("oor_next", 1'b0, 4'hF, 4'h0, 4'h2, 6'h02, 20'h10001, 1'b0);

        // reset while locked with the owner still requesting
        run_cycle("mid_lock", 1'b0, 4'h4, 4'h4, 4'h4, 6'h04, 20'h10002, 1'b1);
        run_cycle("mid_rst", 1'b1, 4'h4, 4'h4, 4'h0, 6'h00, 20'h00000, 1'b0);

        // after reset rr_ptr=0; MAXBURST=1 instance never holds a lock
        rst = 1'b0; req_valid = 4'h1; req_lock = 4'h1;
        #2;
        chk("post_rst.ready", 32'(req_ready), 32'h1);
        chk("mb1.ready0", 32'(req_ready1), 32'h1);
        @(posedge clk); #1;
        chk("post_rst.locked", 32'(locked), 32'h1);
        chk("mb1.locked", 32'(locked1), 32'h0);
        chk("mb1.we", 32'(we1), 32'h01);
        req_valid = 4'hF; req_lock = 4'h0;
        #2;
        chk("release.ready", 32'(req_ready), 32'h1);
        chk("mb1.ready1", 32'(req_ready1), 32'h2);
        @(posedge clk); #1;
        chk("release.locked", 32'(locked), 32'h0);
        chk("mb1.wdata", 32'(wdata1), 32'h10001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
